// File: rtl/mig_app_stub_pkg.sv
// Shared types for the MIG app-interface stub: command codes and the command-queue entry.
// The queue entry carries a fixed-width word index; the stub uses only its low MEM_WORDS_LOG2 bits.
package mig_stub_pkg;

  typedef enum logic [2:0] {
    CMD_WRITE = 3'b000,
    CMD_READ  = 3'b001
  } app_cmd_e;

  localparam int MAX_WORDS_LOG2 = 24;

  // cmd stays a raw 3-bit code so unsupported codes can travel through the queue and be dropped
  typedef struct packed {
    logic [2:0]                cmd;
    logic [MAX_WORDS_LOG2-1:0] word_idx;
  } queue_entry_t;

endpackage

// File: rtl/mig_app_stub_sync_fifo.sv
// Synchronous FIFO with registered occupancy; full/empty depend only on registered state.
// DEPTH must be a power of two, at least 2.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == {(AW+1){1'b0}});
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {(AW+1){1'b0}};
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is never reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mig_app_stub.sv
// Behavioural MIG 7-series app-interface responder: in-order command execution against an
// internal array, fixed read latency, calibration delay and periodic refresh back-pressure.
module mig_app_stub
  import mig_stub_pkg::*;
#(
  parameter int ADDR_W         = 28,
  parameter int DATA_W         = 128,
  parameter int MEM_WORDS_LOG2 = 12,
  parameter int RD_LATENCY     = 8,
  parameter int CALIB_CYCLES   = 200,
  parameter int REFRESH_PERIOD = 780,
  parameter int REFRESH_CYCLES = 16,
  parameter int QUEUE_DEPTH    = 4
) (
  input  logic                clk_core,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   app_addr,
  input  logic [2:0]          app_cmd,
  input  logic                app_en,
  output logic                app_rdy,
  input  logic [DATA_W-1:0]   app_wdf_data,
  input  logic [DATA_W/8-1:0] app_wdf_mask,
  input  logic                app_wdf_wren,
  input  logic                app_wdf_end,
  output logic                app_wdf_rdy,
  output logic [DATA_W-1:0]   app_rd_data,
  output logic                app_rd_data_valid,
  output logic                app_rd_data_end,
  output logic                init_calib_complete
);

  localparam int MASK_W  = DATA_W / 8;
  localparam int WDF_W   = DATA_W + MASK_W;
  localparam int ENTRY_W = $bits(queue_entry_t);
  localparam int WORDS   = 1 << MEM_WORDS_LOG2;

  logic [DATA_W-1:0]         mem [WORDS];
  logic [31:0]               calib_cnt;
  logic                      calib_done;
  logic [31:0]               ref_cnt;
  logic                      refresh_stall;

  queue_entry_t              push_entry;
  queue_entry_t              head;
  logic                      cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic [WDF_W-1:0]          wdf_head;
  logic                      wdf_push, wdf_pop, wdf_full, wdf_empty;
  logic [DATA_W-1:0]         wdf_head_data;
  logic [MASK_W-1:0]         wdf_head_mask;
  logic [MEM_WORDS_LOG2-1:0] head_idx;
  logic                      exec_read, exec_write;

  logic [RD_LATENCY-1:0]     pipe_valid;
  logic [DATA_W-1:0]         pipe_data [RD_LATENCY];
  logic                      unused_bits;

  assign refresh_stall = (REFRESH_PERIOD != 0) && calib_done &&
                         (ref_cnt >= 32'(REFRESH_PERIOD - REFRESH_CYCLES));
  assign app_rdy             = calib_done && !cmd_full && !refresh_stall;
  assign app_wdf_rdy         = calib_done && !wdf_full;
  assign init_calib_complete = calib_done;
  assign app_rd_data_end     = app_rd_data_valid;

  assign cmd_push      = app_en && app_rdy;
  assign wdf_push      = app_wdf_wren && app_wdf_rdy;
  assign head_idx      = head.word_idx[MEM_WORDS_LOG2-1:0];
  assign wdf_head_data = wdf_head[DATA_W-1:0];
  assign wdf_head_mask = wdf_head[WDF_W-1:DATA_W];
  assign unused_bits   = ^{app_wdf_end, app_addr, head.word_idx};

  always_comb begin
    push_entry          = '0;
    push_entry.cmd      = app_cmd;
    push_entry.word_idx = MAX_WORDS_LOG2'(app_addr[3 +: MEM_WORDS_LOG2]);
  end

  sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(QUEUE_DEPTH)) u_cmd_queue (
    .clk       (clk_core),
    .reset     (reset),
    .push      (cmd_push),
    .push_data (push_entry),
    .pop       (cmd_pop),
    .pop_data  (head),
    .full      (cmd_full),
    .empty     (cmd_empty)
  );

  sync_fifo #(.WIDTH(WDF_W), .DEPTH(QUEUE_DEPTH)) u_wdf_fifo (
    .clk       (clk_core),
    .reset     (reset),
    .push      (wdf_push),
    .push_data ({app_wdf_mask, app_wdf_data}),
    .pop       (wdf_pop),
    .pop_data  (wdf_head),
    .full      (wdf_full),
    .empty     (wdf_empty)
  );

  // A write at the head blocks until its data beat exists; nothing executes in a reset cycle.
  always_comb begin
    cmd_pop    = 1'b0;
    wdf_pop    = 1'b0;
    exec_read  = 1'b0;
    exec_write = 1'b0;
    if (!reset && !cmd_empty) begin
      case (head.cmd)
        CMD_WRITE: begin
          if (!wdf_empty) begin
            cmd_pop    = 1'b1;
            wdf_pop    = 1'b1;
            exec_write = 1'b1;
          end else begin
            cmd_pop    = 1'b0;
          end
        end
        CMD_READ: begin
          cmd_pop   = 1'b1;
          exec_read = 1'b1;
        end
        default: cmd_pop = 1'b1;
      endcase
    end else begin
      cmd_pop = 1'b0;
    end
  end

  always_ff @(posedge clk_core) begin
    if (reset) begin
      calib_cnt  <= 32'd0;
      calib_done <= 1'b0;
      ref_cnt    <= 32'd0;
    end else begin
      if (!calib_done) begin
        if (calib_cnt + 32'd1 >= 32'(CALIB_CYCLES)) calib_done <= 1'b1;
        else                                         calib_cnt  <= calib_cnt + 32'd1;
      end
      if (!calib_done || REFRESH_PERIOD == 0)          ref_cnt <= 32'd0;
      else if (ref_cnt == 32'(REFRESH_PERIOD - 1))     ref_cnt <= 32'd0;
      else                                             ref_cnt <= ref_cnt + 32'd1;
    end
  end

  // The array survives reset, so it has no reset branch.
  always_ff @(posedge clk_core) begin
    if (exec_write) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (!wdf_head_mask[b]) mem[head_idx][b*8 +: 8] <= wdf_head_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_core) begin
    if (exec_read) pipe_data[0] <= mem[head_idx];
    for (int i = 1; i < RD_LATENCY; i++) pipe_data[i] <= pipe_data[i-1];
  end

  always_ff @(posedge clk_core) begin
    if (reset) begin
      pipe_valid        <= {RD_LATENCY{1'b0}};
      app_rd_data_valid <= 1'b0;
      app_rd_data       <= {DATA_W{1'b0}};
    end else begin
      pipe_valid[0] <= exec_read;
      for (int i = 1; i < RD_LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
      app_rd_data_valid <= pipe_valid[RD_LATENCY-1];
      if (pipe_valid[RD_LATENCY-1]) app_rd_data <= pipe_data[RD_LATENCY-1];
    end
  end

endmodule

// File: tb/tb_mig_app_stub.sv
// Directed self-checking bench for mig_app_stub at default parameters.
module tb_mig_app_stub;

  localparam logic [2:0] WR = 3'b000;
  localparam logic [2:0] RD = 3'b001;

  logic         clk_core = 1'b0;
  logic         reset;
  logic [27:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;
  logic         init_calib_complete;

  int total = 0;
  int bad   = 0;

  always #5 clk_core = ~clk_core;

  mig_app_stub dut (
    .clk_core            (clk_core),
    .reset               (reset),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rd_data_end     (app_rd_data_end),
    .init_calib_complete (init_calib_complete)
  );

  // Stimulus helpers: start and end just after a falling edge; return after the accepting edge.
  task automatic send_cmd(input logic [2:0] cmd, input logic [27:0] addr);
    int n;
    app_en = 1'b1; app_cmd = cmd; app_addr = addr;
    n = 0;
    while (!app_rdy && n < 2000) begin @(negedge clk_core); n++; end
    if (!app_rdy) begin
      total++; bad++;
      $display("FAIL cmd_accept_timeout: app_rdy=%0b required=1", app_rdy);
    end
    @(negedge clk_core);
    app_en = 1'b0;
  endtask

  task automatic send_data(input logic [127:0] data, input logic [15:0] mask);
    int n;
    app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = data; app_wdf_mask = mask;
    n = 0;
    while (!app_wdf_rdy && n < 2000) begin @(negedge clk_core); n++; end
    if (!app_wdf_rdy) begin
      total++; bad++;
      $display("FAIL wdf_accept_timeout: app_wdf_rdy=%0b required=1", app_wdf_rdy);
    end
    @(negedge clk_core);
    app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
  endtask

  task automatic read_wait(input logic [27:0] addr, output logic [127:0] data,
                           output int lat, output logic got, output logic dend);
    send_cmd(RD, addr);
    got = 1'b0; data = '0; dend = 1'b0; lat = 0;
    for (int j = 0; j < 40; j++) begin
      if (app_rd_data_valid) begin
        got = 1'b1; data = app_rd_data; dend = app_rd_data_end; lat = j;
        break;
      end
      @(negedge clk_core);
    end
  endtask

  task automatic test_reset;
    int n;
    reset = 1'b1;
    repeat (3) @(negedge clk_core);
    total++;
    if ({app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end, init_calib_complete} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_flags: got=%b required=00000",
               {app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end, init_calib_complete});
    end
    total++;
    if (app_rd_data !== 128'd0) begin
      bad++; $display("FAIL reset_rd_data: got=%h required=0", app_rd_data);
    end
    reset = 1'b0;
    n = 0;
    while (!init_calib_complete && n < 400) begin @(negedge clk_core); n++; end
    total++;
    if (n !== 200) begin
      bad++; $display("FAIL calib_latency: got=%0d required=200", n);
    end
    total++;
    if (app_rdy !== 1'b1 || app_wdf_rdy !== 1'b1) begin
      bad++; $display("FAIL rdy_at_calib: app_rdy=%b app_wdf_rdy=%b required=1 1", app_rdy, app_wdf_rdy);
    end
  endtask

  task automatic test_write_read;
    logic [127:0] d; int lat; logic got, dend;
    send_data(128'hDEADBEEF, 16'h0000);
    send_cmd(WR, 28'h40);
    read_wait(28'h40, d, lat, got, dend);
    total++;
    if (got !== 1'b1 || d !== 128'hDEADBEEF) begin
      bad++; $display("FAIL write_read_data: got=%h valid=%b required=%h", d, got, 128'hDEADBEEF);
    end
    total++;
    if (lat !== 9) begin
      bad++; $display("FAIL read_latency: got=%0d required=9", lat);
    end
    total++;
    if (dend !== 1'b1) begin
      bad++; $display("FAIL rd_data_end: got=%b required=1", dend);
    end
    @(negedge clk_core);
    total++;
    if (app_rd_data_valid !== 1'b0) begin
      bad++; $display("FAIL valid_single_pulse: got=%b required=0", app_rd_data_valid);
    end
  endtask

  task automatic test_mask;
    logic [127:0] d; int lat; logic got, dend;
    send_cmd(WR, 28'h40);
    repeat (2) @(negedge clk_core);
    send_data(128'h11, 16'hFFFE);
    read_wait(28'h40, d, lat, got, dend);
    total++;
    if (got !== 1'b1 || d !== 128'hDEADBE11) begin
      bad++; $display("FAIL masked_write: got=%h valid=%b required=%h", d, got, 128'hDEADBE11);
    end
  endtask

  task automatic test_queue_full;
    logic [127:0] exp_d [4];
    logic [127:0] seen [4];
    int cnt, first_c, last_c;
    for (int i = 0; i < 4; i++) exp_d[i] = {4{32'hA5A50000 + 32'(i)}};
    for (int i = 0; i < 4; i++) send_cmd(WR, 28'h100 + 28'(i * 8));
    total++;
    if (app_rdy !== 1'b0) begin
      bad++; $display("FAIL queue_full_rdy: got=%b required=0", app_rdy);
    end
    total++;
    if (app_wdf_rdy !== 1'b1) begin
      bad++; $display("FAIL wdf_rdy_when_cmd_full: got=%b required=1", app_wdf_rdy);
    end
    for (int i = 0; i < 4; i++) send_data(exp_d[i], 16'h0000);
    repeat (2) @(negedge clk_core);
    total++;
    if (app_rdy !== 1'b1) begin
      bad++; $display("FAIL queue_drained_rdy: got=%b required=1", app_rdy);
    end
    for (int i = 0; i < 4; i++) send_cmd(RD, 28'h100 + 28'(i * 8));
    cnt = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 40; c++) begin
      if (app_rd_data_valid) begin
        if (cnt < 4) seen[cnt] = app_rd_data;
        if (first_c < 0) first_c = c;
        last_c = c;
        cnt++;
      end
      @(negedge clk_core);
    end
    total++;
    if (cnt !== 4 || last_c - first_c !== 3) begin
      bad++; $display("FAIL queue_read_beats: count=%0d span=%0d required=4 3", cnt, last_c - first_c);
    end
    for (int i = 0; i < 4 && i < cnt; i++) begin
      total++;
      if (seen[i] !== exp_d[i]) begin
        bad++; $display("FAIL queue_read_data[%0d]: got=%h required=%h", i, seen[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int n, accepts, valids, data_err, runs, run_start, last_start;
    logic prev, rdy;
    n = 0;
    while (!app_rdy && n < 100) begin @(negedge clk_core); n++; end
    accepts = 0; valids = 0; data_err = 0; runs = 0; run_start = -1; last_start = -1;
    prev = 1'b1;
    app_en = 1'b1; app_cmd = RD; app_addr = 28'h40;
    for (int c = 0; c < 1800; c++) begin
      rdy = app_rdy;
      if (rdy) accepts++;
      if (app_rd_data_valid) begin
        valids++;
        if (app_rd_data !== 128'hDEADBE11) data_err++;
      end
      if (prev && !rdy) begin
        if (last_start >= 0) begin
          total++;
          if (c - last_start !== 780) begin
            bad++; $display("FAIL refresh_period: got=%0d required=780", c - last_start);
          end
        end
        last_start = c; run_start = c;
      end
      if (!prev && rdy && run_start >= 0) begin
        runs++;
        total++;
        if (c - run_start !== 16) begin
          bad++; $display("FAIL refresh_stall_len: got=%0d required=16", c - run_start);
        end
      end
      prev = rdy;
      @(negedge clk_core);
    end
    app_en = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (app_rd_data_valid) begin
        valids++;
        if (app_rd_data !== 128'hDEADBE11) data_err++;
      end
      @(negedge clk_core);
    end
    total++;
    if (runs < 2) begin
      bad++; $display("FAIL refresh_runs_seen: got=%0d required>=2", runs);
    end
    total++;
    if (valids !== accepts) begin
      bad++; $display("FAIL valid_vs_accept: valids=%0d required=%0d", valids, accepts);
    end
    total++;
    if (data_err !== 0) begin
      bad++; $display("FAIL b2b_data: bad_beats=%0d required=0", data_err);
    end
  endtask

  task automatic test_reset_flush;
    int n, guard, stray;
    logic [127:0] d; int lat; logic got, dend;
    n = 0; guard = 0;
    app_en = 1'b1; app_cmd = RD; app_addr = 28'h40;
    while (n < 3 && guard < 100) begin
      if (app_rdy) n++;
      @(negedge clk_core);
      guard++;
    end
    app_en = 1'b0;
    reset = 1'b1;
    stray = 0;
    repeat (3) begin
      @(negedge clk_core);
      if (app_rd_data_valid) stray++;
    end
    total++;
    if (app_rdy !== 1'b0 || init_calib_complete !== 1'b0) begin
      bad++; $display("FAIL flush_in_reset: app_rdy=%b calib=%b required=0 0", app_rdy, init_calib_complete);
    end
    reset = 1'b0;
    n = 0;
    while (!init_calib_complete && n < 400) begin
      if (app_rd_data_valid) stray++;
      @(negedge clk_core); n++;
    end
    total++;
    if (stray !== 0) begin
      bad++; $display("FAIL flushed_reads: stray_valids=%0d required=0", stray);
    end
    total++;
    if (n !== 200) begin
      bad++; $display("FAIL recalib_latency: got=%0d required=200", n);
    end
    read_wait(28'h40, d, lat, got, dend);
    total++;
    if (got !== 1'b1 || d !== 128'hDEADBE11 || lat !== 9) begin
      bad++; $display("FAIL array_survives_reset: got=%h valid=%b lat=%0d required=%h 1 9",
                      d, got, lat, 128'hDEADBE11);
    end
  endtask

  initial begin
    reset = 1'b1; app_addr = '0; app_cmd = 3'b000; app_en = 1'b0;
    app_wdf_data = '0; app_wdf_mask = '0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
    test_reset();
    test_write_read();
    test_mask();
    test_queue_full();
    test_back_to_back();
    test_reset_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mig_app_stub.md
# mig_app_stub

Single-clock behavioural responder for the MIG 7-series user (app) interface, standing in for the MIG IP plus the DDR3 device model in fast core-level simulation. It accepts read/write commands and write data from the memory-side initiator in `top`, stores data in an internal array, and returns read data in command order after a fixed latency. It also emulates calibration delay and periodic refresh back-pressure, so initiator handshake logic is exercised without the full PHY.

## Interface
Parameters:
- `ADDR_W`, 28: width of `app_addr`, in 16-bit column units.
- `DATA_W`, 128: app data width (x16 DDR3, 4:1 mode, one beat per burst).
- `MEM_WORDS_LOG2`, 12: log2 of array depth in `DATA_W` words (64 KiB at defaults).
- `RD_LATENCY`, 8: cycles from read execution to `app_rd_data_valid`; must be at least 1.
- `CALIB_CYCLES`, 200: cycles from reset release to `init_calib_complete`.
- `REFRESH_PERIOD`, 780: cycles between refresh stalls; 0 disables refresh stalls.
- `REFRESH_CYCLES`, 16: length of each refresh stall; must be less than `REFRESH_PERIOD`.
- `QUEUE_DEPTH`, 4: depth of the command queue and of the write-data FIFO; power of 2.

Ports:
- `clk_core`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `app_addr`  in  `ADDR_W`  command address; bits [2:0] ignored.
- `app_cmd`  in  3  command: 3'b000 = write, 3'b001 = read; other codes are accepted and dropped.
- `app_en`  in  1  command valid.
- `app_rdy`  out  1  command accepted when `app_en && app_rdy`.
- `app_wdf_data`  in  `DATA_W`  write data.
- `app_wdf_mask`  in  `DATA_W/8`  byte mask; 1 = byte not written.
- `app_wdf_wren`  in  1  write-data valid.
- `app_wdf_end`  in  1  last beat; tied to `app_wdf_wren` by the initiator and ignored by this block.
- `app_wdf_rdy`  out  1  write data accepted when `app_wdf_wren && app_wdf_rdy`.
- `app_rd_data`  out  `DATA_W`  read data.
- `app_rd_data_valid`  out  1  read data valid, one cycle per read.
- `app_rd_data_end`  out  1  equal to `app_rd_data_valid`.
- `init_calib_complete`  out  1  interface usable.

## Operation
- Calibration counter runs from reset release. `init_calib_complete` rises once it reaches `CALIB_CYCLES` and then stays high until the next reset.
- `app_rdy` = calibration complete AND command queue not full AND not stalled for refresh.
- `app_wdf_rdy` = calibration complete AND write-data FIFO not full. Refresh does not gate it.
- Refresh timer starts when calibration completes. Every `REFRESH_PERIOD` cycles, `app_rdy` is held low for `REFRESH_CYCLES` cycles. Execution of already-queued commands continues during the stall.
- Accepted commands enter the command queue, storing the command and word index `app_addr[3 +: MEM_WORDS_LOG2]`. Upper address bits wrap silently.
- Execution is strictly in order, at most one command per cycle, taken from the queue head:
  - Read: array read; the result enters the latency pipeline.
  - Write: executes only if the write-data FIFO is non-empty. It pops one FIFO entry and writes every byte whose mask bit is 0. If the FIFO is empty, the head blocks and everything behind it stalls.
  - Other codes: popped with no effect.
- Write data may arrive before or after its command, up to `QUEUE_DEPTH` beats ahead. Write-data beats are paired with write commands strictly in order.
- Read-after-write to the same address returns the new data, because execution is in order.
- The array is not cleared by reset.

## Timing
- Reset values: `app_rdy`, `app_wdf_rdy`, `app_rd_data_valid`, `app_rd_data_end` and `init_calib_complete` are 0; `app_rd_data` is 0.
- Reset asserted mid-operation flushes the command queue, the write-data FIFO and the read pipeline. In-flight reads are lost, and calibration restarts.
- A read accepted at edge N with an empty queue executes at edge N+1. Its data appears with `app_rd_data_valid` high for one cycle after edge N+1+`RD_LATENCY`.
- Back-to-back reads produce back-to-back valid cycles. There is no output back-pressure.
- A write accepted at edge N, with its data already present, updates the array at edge N+1. A read accepted at N+1 sees the new data.
- Queue full and a push in the same cycle: the push cannot occur because `app_rdy` is already low.
- Simultaneous push and pop on a full queue: the pop frees a slot only from the next cycle. Readies depend only on registered state.

## Structure
- Shared package `mig_stub_pkg` holds:
  - `app_cmd_e` (CMD_WRITE = 3'b000, CMD_READ = 3'b001);
  - the queue-entry struct (cmd, word index).
- Sub-module `sync_fifo`, parameterized width and depth, with full/empty flags. It is instantiated twice: command queue and write-data FIFO.
- The read pipeline is a `RD_LATENCY`-deep valid/data shift register inside the stub.

## Test plan
- Reset, then idle: `init_calib_complete` rises exactly 200 cycles after reset release, and `app_rdy` rises with it.
- Write 128'hDEADBEEF at addr 0x40 with mask 0, then read 0x40: data equals 128'hDEADBEEF, with valid 9 cycles after read acceptance.
- Write addr 0x40 with mask 16'hFFFE and data 128'h11, following the previous test: read returns 128'hDEADBE11.
- Issue 4 write commands with no data: `app_rdy` drops when full; data then arrives one beat per cycle; all 4 addresses read back correctly in order.
- Hold `app_en` with reads continuously: `app_rdy` goes low for 16 cycles every 780. There are no lost or duplicated `app_rd_data_valid` pulses, and the valid count equals the accept count.
- Assert `reset` with 3 reads in flight: no `app_rd_data_valid` after reset. Array contents survive, and a later read of 0x40 still returns 128'hDEADBE11.
